// File: rtl/led_pkg.sv
// led_pkg: mode and breathe-ramp state encodings shared by rgb_pwm_driver and pwm_channel
package led_pkg;
    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STEADY  = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;
    typedef enum logic {
        RAMP_UP   = 1'b0,
        RAMP_DOWN = 1'b1
    } ramp_state_e;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one colour's compare/force stage; in clk, rst, cnt (PWM counter), duty (shadow), mode, blink_on, ramp; out lit (registered, 1 = on)
module pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic [PWM_BITS-1:0] duty,
    input  mode_e               mode,
    input  logic                blink_on,
    input  logic [PWM_BITS-1:0] ramp,
    output logic                lit
);
    logic [PWM_BITS-1:0] d;
    logic                en;
    always_comb begin
        d  = (mode == MODE_BREATHE && ramp < duty) ? ramp : duty;
        en = mode == MODE_STEADY || mode == MODE_BREATHE || (mode == MODE_BLINK && blink_on);
    end
    always_ff @(posedge clk) lit <= rst ? 1'b0 : en && (&d || cnt < d);
endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: N_LED tricolour PWM driver (off/steady/blink/breathe); in clk, rst, r_duty/g_duty/b_duty, mode; out R, G, B, period_start
module rgb_pwm_driver
    import led_pkg::*;
#(
    parameter int N_LED         = 2,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 4,
    parameter int BLINK_PERIODS = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_LED*PWM_BITS-1:0] r_duty,
    input  logic [N_LED*PWM_BITS-1:0] g_duty,
    input  logic [N_LED*PWM_BITS-1:0] b_duty,
    input  logic [2*N_LED-1:0]        mode,
    output logic [N_LED-1:0]          R,
    output logic [N_LED-1:0]          G,
    output logic [N_LED-1:0]          B,
    output logic                      period_start
);
    localparam int PSW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int BCW = BLINK_PERIODS > 1 ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PWM_BITS-1:0] TOP = '1;
    logic [PSW-1:0]              presc;
    logic [PWM_BITS-1:0]         cnt, ramp, ramp_nx;
    logic [BCW-1:0]              blink_cnt;
    logic                        blink_on, first, tick, wrap, load, blink_end;
    ramp_state_e                 st, st_nx;
    logic [N_LED*PWM_BITS-1:0]   r_sh, g_sh, b_sh, r_eff, g_eff, b_eff;
    logic [2*N_LED-1:0]          mode_sh, mode_eff;
    // first marks the boundary right after reset: the shadows load there, and the
    // compare on that same edge already needs the fresh inputs, hence the bypass.
    always_comb begin
        tick      = presc == PSW'(PRESCALE - 1);
        wrap      = tick && &cnt;
        load      = wrap || first;
        blink_end = blink_cnt == BCW'(BLINK_PERIODS - 1);
        r_eff     = first ? r_duty : r_sh;
        g_eff     = first ? g_duty : g_sh;
        b_eff     = first ? b_duty : b_sh;
        mode_eff  = first ? mode : mode_sh;
        ramp_nx   = st == RAMP_UP ? ramp + PWM_BITS'(1) : ramp - PWM_BITS'(1);
        st_nx     = (st == RAMP_UP && ramp == TOP - PWM_BITS'(1)) ? RAMP_DOWN :
                    (st == RAMP_DOWN && ramp == PWM_BITS'(1)) ? RAMP_UP : st;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            presc        <= '0;
            cnt          <= '0;
            blink_cnt    <= '0;
            blink_on     <= 1'b1;
            ramp         <= '0;
            st           <= RAMP_UP;
            first        <= 1'b1;
            period_start <= 1'b0;
            r_sh         <= '0;
            g_sh         <= '0;
            b_sh         <= '0;
            mode_sh      <= '0;
        end else begin
            presc        <= tick ? '0 : presc + PSW'(1);
            cnt          <= tick ? cnt + PWM_BITS'(1) : cnt;
            period_start <= presc == '0 && cnt == '0;
            first        <= 1'b0;
            if (load) begin
                r_sh    <= r_duty;
                g_sh    <= g_duty;
                b_sh    <= b_duty;
                mode_sh <= mode;
            end
            if (wrap) begin
                blink_cnt <= blink_end ? '0 : blink_cnt + BCW'(1);
                blink_on  <= blink_end ? ~blink_on : blink_on;
                ramp      <= ramp_nx;
                st        <= st_nx;
            end
        end
    end
    for (genvar i = 0; i < N_LED; i++) begin : g_led
        pwm_channel #(.PWM_BITS(PWM_BITS)) u_r (
            .clk(clk), .rst(rst), .cnt(cnt), .duty(r_eff[i*PWM_BITS +: PWM_BITS]),
            .mode(mode_e'(mode_eff[2*i +: 2])), .blink_on(blink_on), .ramp(ramp), .lit(R[i])
        );
        pwm_channel #(.PWM_BITS(PWM_BITS)) u_g (
            .clk(clk), .rst(rst), .cnt(cnt), .duty(g_eff[i*PWM_BITS +: PWM_BITS]),
            .mode(mode_e'(mode_eff[2*i +: 2])), .blink_on(blink_on), .ramp(ramp), .lit(G[i])
        );
        pwm_channel #(.PWM_BITS(PWM_BITS)) u_b (
            .clk(clk), .rst(rst), .cnt(cnt), .duty(b_eff[i*PWM_BITS +: PWM_BITS]),
            .mode(mode_e'(mode_eff[2*i +: 2])), .blink_on(blink_on), .ramp(ramp), .lit(B[i])
        );
    end
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: scoreboard bench; per-period high-clock counts checked against queued expectations
module tb_rgb_pwm_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] r_duty = '0, g_duty = '0, b_duty = '0;
    logic [3:0] mode = '0;
    logic [1:0] R, G, B;
    logic       period_start;

    rgb_pwm_driver #(.N_LED(2), .PWM_BITS(4), .PRESCALE(2), .BLINK_PERIODS(2)) dut (
        .clk(clk), .rst(rst), .r_duty(r_duty), .g_duty(g_duty), .b_duty(b_duty),
        .mode(mode), .R(R), .G(G), .B(B), .period_start(period_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int              idx;
        logic [5:0][7:0] hi;
    } exp_t;

    exp_t       sb[$];
    int         passed = 0, total = 0, pidx = 0, len = 0;
    int         hi[6], run[6];
    logic [5:0] lead, o;
    logic       open = 1'b0;

    function automatic void check(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endfunction

    function automatic int hb(int d, int ra);
        int m;
        m = d < ra ? d : ra;
        return m == 15 ? 32 : 2 * m;
    endfunction

    // Monitor: a period closes at the next period_start; its counts are compared
    // with the queued record tagged for that period.
    initial forever begin
        @(negedge clk);
        o = {B, G, R};
        if (rst) open = 1'b0;
        else begin
            if (period_start === 1'b1) begin
                if (open) begin
                    check($sformatf("p%0d_len", pidx), len, 32);
                    while (sb.size() > 0 && sb[0].idx < pidx) begin
                        check($sformatf("p%0d_missed", sb[0].idx), pidx, sb[0].idx);
                        void'(sb.pop_front());
                    end
                    if (sb.size() > 0 && sb[0].idx == pidx) begin
                        exp_t e;
                        e = sb.pop_front();
                        for (int c = 0; c < 6; c++) begin
                            check($sformatf("p%0d_ch%0d_high", pidx, c), hi[c], int'(e.hi[c]));
                            check($sformatf("p%0d_ch%0d_aligned", pidx, c), run[c], int'(e.hi[c]));
                        end
                    end
                end
                pidx++;
                open = 1'b1;
                len  = 0;
                lead = '1;
                for (int c = 0; c < 6; c++) begin
                    hi[c]  = 0;
                    run[c] = 0;
                end
            end
            if (open) begin
                len++;
                for (int c = 0; c < 6; c++) begin
                    if (o[c] === 1'b1) begin
                        hi[c]++;
                        if (lead[c]) run[c]++;
                    end else lead[c] = 1'b0;
                end
            end
        end
    end

    task automatic setp(input logic [3:0] m, input int r0, r1, g0, g1, b0, b1,
                        input int e0, e1, e2, e3, e4, e5);
        exp_t x;
        r_duty = {4'(r1), 4'(r0)};
        g_duty = {4'(g1), 4'(g0)};
        b_duty = {4'(b1), 4'(b0)};
        mode   = m;
        x.idx  = pidx + 1;
        x.hi   = {8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
        sb.push_back(x);
    endtask

    task automatic wait_boundary();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < 40);
        check("boundary_seen", int'(period_start === 1'b1), 1);
        #1;
    endtask

    // Inputs change at clock 10 of the current period and must only affect the next one.
    task automatic period(input logic [3:0] m, input int r0, r1, g0, g1, b0, b1,
                          input int e0, e1, e2, e3, e4, e5);
        repeat (9) @(negedge clk);
        #1;
        setp(m, r0, r1, g0, g1, b0, b1, e0, e1, e2, e3, e4, e5);
        wait_boundary();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, limit 200000", $time);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_R", int'(R), 0);
        check("rst_G", int'(G), 0);
        check("rst_B", int'(B), 0);
        check("rst_period_start", int'(period_start), 0);
        #1;
        setp(4'b0101, 4, 9, 1, 0, 4, 7, 8, 18, 2, 0, 8, 14);
        rst = 1'b0;
        @(negedge clk);
        check("ps_after_release", int'(period_start), 1);
        #1;
        period(4'b0101, 4, 9, 1, 0, 4, 7, 8, 18, 2, 0, 8, 14);
        period(4'b0101, 4, 9, 1, 0, 4, 7, 8, 18, 2, 0, 8, 14);
        period(4'b0101, 4, 9, 1, 15, 12, 7, 8, 18, 2, 32, 24, 14);
        period(4'b0101, 4, 9, 1, 15, 12, 7, 8, 18, 2, 32, 24, 14);
        period(4'b0101, 4, 9, 1, 15, 12, 7, 8, 18, 2, 32, 24, 14);
        period(4'b1010, 8, 15, 0, 3, 8, 1, 0, 0, 0, 0, 0, 0);
        period(4'b1010, 8, 15, 0, 3, 8, 1, 0, 0, 0, 0, 0, 0);
        period(4'b1010, 8, 15, 0, 3, 8, 1, 16, 32, 0, 6, 16, 2);
        period(4'b1010, 8, 15, 0, 3, 8, 1, 16, 32, 0, 6, 16, 2);
        period(4'b1010, 8, 15, 0, 3, 8, 1, 0, 0, 0, 0, 0, 0);
        period(4'b1010, 8, 15, 0, 3, 8, 1, 0, 0, 0, 0, 0, 0);
        period(4'b0100, 15, 15, 15, 15, 15, 15, 0, 32, 0, 32, 0, 32);
        for (int k = 14; k <= 32; k++) begin
            int ra;
            ra = (k - 1) % 30;
            if (ra > 15) ra = 30 - ra;
            period(4'b1111, 15, 5, 15, 0, 10, 15,
                   hb(15, ra), hb(5, ra), hb(15, ra), 0, hb(10, ra), hb(15, ra));
        end
        repeat (9) @(negedge clk);
        #1;
        r_duty = '1;
        g_duty = '1;
        b_duty = '1;
        mode   = 4'b0101;
        wait_boundary();
        repeat (19) @(negedge clk);
        check("lit_before_rst", int'({R, G, B}), 63);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_R", int'(R), 0);
        check("midrst_G", int'(G), 0);
        check("midrst_B", int'(B), 0);
        check("midrst_period_start", int'(period_start), 0);
        #1;
        setp(4'b1001, 4, 8, 2, 15, 0, 6, 8, 16, 4, 32, 0, 12);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ps_after_midrst", int'(period_start), 1);
        #1;
        period(4'b1001, 4, 8, 2, 15, 0, 6, 8, 16, 4, 32, 0, 12);
        period(4'b1001, 4, 8, 2, 15, 0, 6, 8, 0, 4, 0, 0, 0);
        wait_boundary();
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
